// File: rtl/des_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_pkg : DES S-box and P tables, engine state encoding, helper functions
// Rev 1.0
// ---------------------------------------------------------------------------
package des_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Each S-box is 64 nibbles, index 0 leftmost; index = {row, col}.
  localparam logic [0:7][0:63][3:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Output bit i (1 = MSB) takes input bit P_TABLE[i-1].
  localparam int P_TABLE [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic int des_groups(input int lanes);
    return 8 / lanes;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      y[31-i] = x[32-P_TABLE[i]];
    end
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox_lut.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_sbox_lut : combinational lookup of one of the eight DES S-boxes
// Rev 1.0
// ---------------------------------------------------------------------------
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0] i_sel,
  input  logic [5:0] i_bin,
  output logic [3:0] o_bout
);

  logic [5:0] w_idx;

  // Outer bits pick the row, inner four bits the column.
  assign w_idx  = {i_bin[5], i_bin[0], i_bin[4:1]};
  assign o_bout = SBOX[i_sel][w_idx];

endmodule
`default_nettype wire

// File: rtl/des_sbox_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// des_sbox_engine : multi-cycle DES S-box stage, LANES boxes per cycle, opt. P
// Rev 1.0
// ---------------------------------------------------------------------------
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int LANES   = 2,
  parameter bit APPLY_P = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [47:0] i_din,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_dout
);

  localparam int GROUPS = des_groups(LANES);
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end
  endgenerate

  logic [1:0]    r_state;
  logic [GW-1:0] r_grp;
  logic [47:0]   r_din;
  logic [31:0]   r_acc;
  logic [31:0]   r_dout;

  logic [2:0]    w_sel  [LANES];
  logic [5:0]    w_bin  [LANES];
  logic [3:0]    w_bout [LANES];
  logic [31:0]   w_acc_next;
  logic [31:0]   w_result;
  logic          w_in_ready;
  logic          w_accept;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_sel[l] = 3'(32'(r_grp) * LANES + l);
      assign w_bin[l] = r_din[47 - 6*w_sel[l] -: 6];

      des_sbox_lut u_lut (
        .i_sel  (w_sel[l]),
        .i_bin  (w_bin[l]),
        .o_bout (w_bout[l])
      );
    end
  endgenerate

  // Merge this cycle's lane results so the final group lands in dout directly.
  always_comb begin
    w_acc_next = r_acc;
    for (int l = 0; l < LANES; l++) begin
      w_acc_next[31 - 4*w_sel[l] -: 4] = w_bout[l];
    end
  end

  assign w_result   = APPLY_P ? des_p(w_acc_next) : w_acc_next;
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grp   <= '0;
      r_din   <= '0;
      r_acc   <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_din   <= i_din;
            r_grp   <= '0;
            r_acc   <= '0;
            r_state <= S_BUSY;
          end else if ((r_state == S_DONE) && i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          if (r_grp == GRP_LAST) begin
            r_grp   <= '0;
            r_dout  <= w_result;
            r_state <= S_DONE;
          end else begin
            r_grp <= r_grp + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = (r_state == S_DONE);
  assign o_dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_des_sbox_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_des_sbox_engine : vectors, stall/reset sequences and scoreboarded traffic
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_des_sbox_engine;

  localparam int NI     = 5;
  localparam int NWORDS = 1000;
  localparam int CFG_L [NI] = '{1, 2, 4, 8, 2};
  localparam bit CFG_P [NI] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  localparam int TB_S [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };
  localparam int TB_P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  typedef struct {
    int          inst;
    logic [47:0] din;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [NI];
  logic        out_ready [NI];
  logic [47:0] din       [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic [31:0] dout      [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      des_sbox_engine #(.LANES(CFG_L[g]), .APPLY_P(CFG_P[g])) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid[g]),
        .o_in_ready  (in_ready[g]),
        .i_din       (din[g]),
        .o_out_valid (out_valid[g]),
        .i_out_ready (out_ready[g]),
        .o_dout      (dout[g])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_f(input logic [47:0] d, input bit p);
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    int          r;
    int          c;
    s = '0;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      b = d[47-6*k -: 6];
      r = 2 * int'(b[5]) + int'(b[0]);
      c = int'(b[4:1]);
      s[31-4*k -: 4] = 4'(TB_S[k][r*16+c]);
    end
    if (!p) return s;
    for (int i = 0; i < 32; i++) y[31-i] = s[32-TB_P[i]];
    return y;
  endfunction

  // One word on an idle instance: latency, value, and return to idle.
  task automatic run_one(input int k, input logic [47:0] d, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    din[k] = d; in_valid[k] = 1'b1; out_ready[k] = 1'b0;
    #1 chk($sformatf("in_ready_idle_i%0d", k), in_ready[k], 1);
    @(negedge clk);
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency_i%0d", k), lat, 8 / CFG_L[k]);
    chk($sformatf("dout_i%0d_%h", k, d), dout[k], exp);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk($sformatf("out_valid_drop_i%0d", k), out_valid[k], 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] sbq[$];
    int          lat;
    int          sent;
    int          recv;
    int          cyc;
    bit          fire_in;

    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; din[i] = '0;
    end

    vecs.push_back('{0, 48'h000000000000, 32'hEFA72C4D});
    vecs.push_back('{1, 48'h000000000000, 32'hEFA72C4D});
    vecs.push_back('{2, 48'h000000000000, 32'hEFA72C4D});
    vecs.push_back('{3, 48'h000000000000, 32'hEFA72C4D});
    vecs.push_back('{0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB});
    vecs.push_back('{2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB});
    vecs.push_back('{3, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB});
    vecs.push_back('{0, 48'h6117BA866527, 32'h5C82B597});
    vecs.push_back('{1, 48'h6117BA866527, 32'h5C82B597});
    vecs.push_back('{3, 48'h6117BA866527, 32'h5C82B597});
    vecs.push_back('{4, 48'h6117BA866527, 32'h234AA9BB});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_out_valid_i%0d", i), out_valid[i], 0);
      chk($sformatf("rst_in_ready_i%0d", i), in_ready[i], 1);
      chk($sformatf("rst_dout_i%0d", i), dout[i], 0);
    end

    foreach (vecs[v]) run_one(vecs[v].inst, vecs[v].din, vecs[v].exp);

    // Downstream stall in DONE, then back-to-back accept on release.
    @(negedge clk);
    din[1] = 48'h0; in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(negedge clk);
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 20) begin @(negedge clk); lat++; end
    chk("stall_first_latency", lat, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid[1], 1);
      chk("stall_dout", dout[1], 32'hEFA72C4D);
      chk("stall_in_ready", in_ready[1], 0);
    end
    din[1] = 48'hFFFFFFFFFFFF; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    #1 chk("b2b_in_ready", in_ready[1], 1);
    @(negedge clk);
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    chk("b2b_busy_no_valid", out_valid[1], 0);
    chk("b2b_busy_in_ready", in_ready[1], 0);
    lat = 0;
    while (!out_valid[1] && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_second_latency", lat, 4);
    chk("b2b_second_dout", dout[1], 32'hD9CE3DCB);
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;

    // Reset in the middle of a LANES=1 block.
    @(negedge clk);
    din[0] = 48'h6117BA866527; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_dout", dout[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_in_ready", in_ready[0], 1);
    repeat (10) @(negedge clk);
    chk("midrst_no_output", out_valid[0], 0);
    run_one(0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);

    // Throttled random traffic against the scoreboard.
    sent = 0; recv = 0; cyc = 0; fire_in = 1'b0;
    while (recv < NWORDS && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (fire_in) in_valid[4] = 1'b0;
      if (!in_valid[4] && sent < NWORDS && $urandom_range(0, 3) != 0) begin
        din[4] = {16'($urandom), $urandom};
        in_valid[4] = 1'b1;
      end
      out_ready[4] = ($urandom_range(0, 3) != 0);
      #1;
      fire_in = in_valid[4] && in_ready[4];
      if (fire_in) begin
        sbq.push_back(ref_f(din[4], 1'b1));
        sent++;
      end
      if (out_valid[4] && out_ready[4]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_extra_output: got %h, expected no output", dout[4]);
        end else begin
          chk("rand_dout", dout[4], sbq.pop_front());
        end
        recv++;
      end
    end
    @(negedge clk);
    in_valid[4] = 1'b0; out_ready[4] = 1'b0;
    chk("rand_count_in_out", recv, sent);
    chk("rand_all_sent", sent, NWORDS);
    chk("rand_sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
